// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports (port 1 wins on collision),
// two combinational read ports with optional same-cycle forwarding, and a
// per-register busy scoreboard. After reset a sweep zeroes registers
// 1..NREG-1 one per cycle; the file is unusable until the sweep completes.
//
// Handshake: there is no valid/ready pair on the access ports. "ready" is a
// level qualifier: while it is low every write, sb_set and read is ignored
// (reads return 0, busy returns 0); once high, each enabled request is
// accepted on the rising edge it is presented at, with no backpressure.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  output logic            dbg_state,
  output logic [AW-1:0]   dbg_idx,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            busy1,
  output logic            busy2
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy;

  // Accepted requests; address 0 is hard-wired to zero and never tracked.
  logic wr0, wr1, sb_ok;
  assign wr0   = ready && we0    && (wa0 != '0);
  assign wr1   = ready && we1    && (wa1 != '0);
  assign sb_ok = ready && sb_set && (sb_addr != '0);

  assign ready     = (state == READY);
  assign dbg_state = (state == READY);
  assign dbg_idx   = idx;

  // Sweep FSM: restart at idx=1 on reset, step once per cycle, go READY
  // on the cycle that clears the last register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= AW'(1);
    end else if (state == CLEAR) begin
      idx <= idx + 1'b1;
      if (idx == AW'(NREG - 1)) state <= READY;
    end
  end

  // Storage: sweep writes zeros; in READY port 1 is assigned last so it wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        regs[idx] <= '0;
      end else begin
        if (wr0) regs[wa0] <= wd0;
        if (wr1) regs[wa1] <= wd1;
      end
    end
  end

  // Scoreboard: writes retire pending bits, a same-cycle set takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr0)   busy[wa0]     <= 1'b0;
      if (wr1)   busy[wa1]     <= 1'b0;
      if (sb_ok) busy[sb_addr] <= 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = regs[ra];
    if (BYPASS != 0) begin
      if (wr1 && (wa1 == ra))      v = wd1;
      else if (wr0 && (wa0 == ra)) v = wd0;
    end
    if (!ready || (ra == '0)) v = '0;
    return v;
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] ra);
    logic b;
    b = busy[ra];
    if ((BYPASS != 0) && ((wr1 && (wa1 == ra)) || (wr0 && (wa0 == ra)))
        && !(sb_ok && (sb_addr == ra)))
      b = 1'b0;
    if (!ready || (ra == '0)) b = 1'b0;
    return b;
  endfunction

  // Combinational read ports.
  always_comb begin
    rd1   = read_data(ra1);
    rd2   = read_data(ra2);
    busy1 = read_busy(ra1);
    busy2 = read_busy(ra2);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one forwarding and one non-forwarding instance share
// the same stimulus and are checked against a behavioural model.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic            we0, we1, sb_set;
  logic [AW-1:0]   wa0, wa1, ra1, ra2, sb_addr;
  logic [XLEN-1:0] wd0, wd1;

  logic            ready_b, ready_n, st_b, st_n;
  logic [AW-1:0]   idx_b, idx_n;
  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            busy1_b, busy2_b, busy1_n, busy2_n;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b), .dbg_state(st_b), .dbg_idx(idx_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy1(busy1_b), .busy2(busy2_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .ready(ready_n), .dbg_state(st_n), .dbg_idx(idx_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy1(busy1_n), .busy2(busy2_n)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] mem [NREG];
  logic            bsy [NREG];
  int              clr_cnt;   // cycles of sweep completed since reset release

  function automatic logic m_ready();
    return clr_cnt == NREG - 1;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra, input bit fwd);
    if (!m_ready() || ra == 0) return '0;
    if (fwd && we1 && wa1 == ra) return wd1;
    if (fwd && we0 && wa0 == ra) return wd0;
    return mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra, input bit fwd);
    if (!m_ready() || ra == 0) return 1'b0;
    if (fwd && ((we1 && wa1 == ra) || (we0 && wa0 == ra)) && !(sb_set && sb_addr == ra))
      return 1'b0;
    return bsy[ra];
  endfunction

  task automatic model_update();
    if (reset) begin
      clr_cnt = 0;
      for (int i = 0; i < NREG; i++) bsy[i] = 1'b0;
    end else if (!m_ready()) begin
      clr_cnt++;
      if (m_ready()) for (int i = 0; i < NREG; i++) mem[i] = '0;
    end else begin
      if (we0 && wa0 != 0) begin mem[wa0] = wd0; bsy[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin mem[wa1] = wd1; bsy[wa1] = 1'b0; end
      if (sb_set && sb_addr != 0) bsy[sb_addr] = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("ready_b", 32'(ready_b), 32'(m_ready()));
    check("ready_n", 32'(ready_n), 32'(m_ready()));
    check("state_b", 32'(st_b), 32'(m_ready()));
    if (!m_ready()) check("idx_b", 32'(idx_b), 32'(clr_cnt + 1));
    check("rd1_b", rd1_b, exp_rd(ra1, 1'b1));
    check("rd2_b", rd2_b, exp_rd(ra2, 1'b1));
    check("rd1_n", rd1_n, exp_rd(ra1, 1'b0));
    check("rd2_n", rd2_n, exp_rd(ra2, 1'b0));
    check("busy1_b", 32'(busy1_b), 32'(exp_busy(ra1, 1'b1)));
    check("busy2_b", 32'(busy2_b), 32'(exp_busy(ra2, 1'b1)));
    check("busy1_n", 32'(busy1_n), 32'(exp_busy(ra1, 1'b0)));
    check("busy2_n", 32'(busy2_n), 32'(exp_busy(ra2, 1'b0)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    reset   = 1'b0;
    we0     = 1'($urandom_range(0, 1));
    we1     = 1'($urandom_range(0, 1));
    sb_set  = 1'($urandom_range(0, 1));
    wa0     = rand_addr();
    wa1     = rand_addr();
    ra1     = rand_addr();
    ra2     = rand_addr();
    sb_addr = rand_addr();
    wd0     = $urandom;
    wd1     = $urandom;
  endtask

  task automatic count_sweep(input string tag);
    int cnt;
    cnt = 0;
    while (!ready_b && cnt < 100) begin
      rand_inputs();
      step();
      cnt++;
    end
    check(tag, 32'(cnt), 32'(NREG - 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    clr_cnt = 0;
    for (int i = 0; i < NREG; i++) begin mem[i] = '0; bsy[i] = 1'b0; end
    idle();
    reset = 1'b1;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra1 = '0; ra2 = '0; sb_addr = '0;

    // Reset held with requests presented: outputs stay quiet.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      reset = 1'b1;
      step();
    end

    // Sweep length after release, with ignored traffic during the sweep.
    idle();
    count_sweep("sweep_len");

    // Every register reads zero after the sweep.
    for (int i = 1; i < NREG; i++) begin
      idle(); ra1 = AW'(i); ra2 = AW'(NREG - i);
      step();
    end

    // Same-address collision: port 1 wins.
    idle();
    we0 = 1'b1; wa0 = 5; wd0 = 32'hAAAA0000;
    we1 = 1'b1; wa1 = 5; wd1 = 32'h12345678;
    step();
    idle(); ra1 = 5; #1;
    check("collide_b", rd1_b, 32'h12345678);
    check("collide_n", rd1_n, 32'h12345678);
    step();

    // Forwarding vs one-cycle latency.
    idle(); we0 = 1'b1; wa0 = 7; wd0 = 32'h01020304;
    step();
    idle(); we1 = 1'b1; wa1 = 7; wd1 = 32'hDEADBEEF; ra2 = 7; #1;
    check("fwd_b", rd2_b, 32'hDEADBEEF);
    check("nofwd_old", rd2_n, 32'h01020304);
    step();
    idle(); ra2 = 7; #1;
    check("nofwd_new", rd2_n, 32'hDEADBEEF);
    step();

    // Scoreboard set / set-vs-write / write alone.
    idle(); sb_set = 1'b1; sb_addr = 9; ra1 = 9;
    step();
    idle(); ra1 = 9; #1;
    check("sb_set", 32'(busy1_b), 32'd1);
    we0 = 1'b1; wa0 = 9; wd0 = 32'h55; sb_set = 1'b1; sb_addr = 9;
    step();
    idle(); ra1 = 9; #1;
    check("sb_wins_b", 32'(busy1_b), 32'd1);
    check("sb_wins_n", 32'(busy1_n), 32'd1);
    we0 = 1'b1; wa0 = 9; wd0 = 32'h66;
    step();
    idle(); ra1 = 9; #1;
    check("sb_clr_b", 32'(busy1_b), 32'd0);
    check("sb_clr_n", 32'(busy1_n), 32'd0);
    step();

    // Register 0 ignores writes and scoreboard sets.
    idle(); we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFFFFFF;
    we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFFFFFF; sb_set = 1'b1; sb_addr = 0; ra1 = 0;
    step();
    idle(); ra1 = 0; #1;
    check("x0_rd", rd1_b, 32'd0);
    check("x0_busy", 32'(busy1_b), 32'd0);
    step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      step();
    end

    // Reset in the middle of the sweep (at idx=12) restarts it.
    idle(); reset = 1'b1;
    step();
    idle();
    for (int i = 0; i < 11; i++) begin
      rand_inputs();
      step();
    end
    check("mid_idx", 32'(idx_b), 32'd12);
    idle(); reset = 1'b1;
    step();
    idle();
    count_sweep("mid_sweep_len");

    // Reset from READY also restarts a full sweep.
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      step();
    end
    idle(); reset = 1'b1;
    step();
    idle();
    count_sweep("ready_reset_len");
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two and at least 4.
REQ-003 SHALL have parameter AW, default 5, address width; equals log2(NREG).
REQ-004 SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ready  output  1  high when the clear sweep is done and the file is usable.
REQ-008 SHALL have ports we0/wa0/wd0  input  1/AW/XLEN  write port 0: enable, address, data.
REQ-009 SHALL have ports we1/wa1/wd1  input  1/AW/XLEN  write port 1: enable, address, data; higher priority.
REQ-010 SHALL have ports ra1/ra2  input  AW  read addresses.
REQ-011 SHALL have ports rd1/rd2  output  XLEN  read data, combinational.
REQ-012 SHALL have ports sb_set/sb_addr  input  1/AW  scoreboard set request: marks a register as having a pending write.
REQ-013 SHALL have ports busy1/busy2  output  1  scoreboard busy status of ra1/ra2, combinational.

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and READY; ready = (state==READY).
REQ-015 In CLEAR, SHALL write zero to register idx on each non-reset cycle and increment idx, starting at idx=1.
REQ-016 SHALL transition CLEAR->READY on the cycle it writes idx=NREG-1, so ready rises exactly NREG-1 cycles after reset deasserts.
REQ-017 While ready=0, SHALL ignore we0, we1 and sb_set, and SHALL drive rd1=rd2=0 and busy1=busy2=0.
REQ-018 In READY, SHALL write wd0 to wa0 when we0=1 and wd1 to wa1 when we1=1, updating on the next edge.
REQ-019 When we0 and we1 target the same address in the same cycle, SHALL store wd1.
REQ-020 Register 0 SHALL read as 0 at all times; writes, sb_set and busy status for address 0 SHALL be ignored, with busy always 0.
REQ-021 With BYPASS=0, rdN SHALL equal the stored value of raN, giving write-to-read latency of one cycle.
REQ-022 With BYPASS=1, rdN SHALL return the same-cycle write data when raN matches an enabled write address, with wd1 taking priority over wd0, otherwise the stored value.
REQ-023 Scoreboard: SHALL keep one busy bit per register; sb_set=1 in READY SHALL set busy[sb_addr] at the next edge.
REQ-024 An enabled write in READY SHALL clear busy[wa] at the next edge.
REQ-025 When sb_set and a write target the same address in the same cycle, set SHALL win and the bit SHALL end busy.
REQ-026 busyN SHALL equal busy[raN]; with BYPASS=1 it SHALL also read 0 when an enabled write to raN occurs in the same cycle and no sb_set targets raN in that cycle.
REQ-027 Register contents, busy bits, idx and state SHALL have no other update paths.

Reset
REQ-028 While reset=1, SHALL at each edge set state=CLEAR, idx=1 and all busy bits to 0; no sweep progress SHALL occur during reset.
REQ-029 Reset outputs SHALL be ready=0, rd1=rd2=0 and busy1=busy2=0.
REQ-030 Reset asserted mid-sweep or in READY SHALL restart the sweep from idx=1.

Verification
REQ-031 Defaults; release reset -> ready=0 for exactly 31 cycles, then 1; every register 1..31 then reads 0.
REQ-032 READY; we0 wa0=5 wd0=0xAAAA0000 and we1 wa1=5 wd1=0x12345678 in the same cycle -> next cycle rd1 (ra1=5) = 0x12345678.
REQ-033 BYPASS=1; we1 wa1=7 wd1=0xDEADBEEF, ra2=7 in the same cycle -> rd2=0xDEADBEEF in that cycle; BYPASS=0 -> old value, new value one cycle later.
REQ-034 sb_set sb_addr=9 -> busy1 (ra1=9) =1 next cycle; a we0 wa0=9 write together with sb_set sb_addr=9 -> still 1; a write alone -> 0.
REQ-035 Write x0 with 0xFFFFFFFF and sb_set x0 -> rd1 (ra1=0) =0 and busy1=0; assert reset at sweep idx=12 -> ready stays 0 for a full 31 cycles after release.
